rank_serializer: RTL and testbench

- Sits directly downstream of the 16-lane parallel ranking stage.
- Captures one frame per score_done pulse: each lane's 20-bit data word plus its 8-bit rank score. Rank 1 is the smallest value and rank N the largest.
- Scatters the words into a rank-ordered buffer and checks that the ranks form a valid permutation.
- Streams the TOP_K largest words out, largest first, over a valid/ready interface to the consumer.

---
 rtl/rank_serializer_if.sv | 25 ++
 rtl/rank_serializer.sv | 148 ++++++++++++++
 tb/tb_rank_serializer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rank_serializer_if.sv
// Frame capture and rank-ordered output stream between the ranking stage,
// rank_serializer and its consumer.
interface rank_serializer_if #(
    parameter int N      = 16,
    parameter int DATA_W = 20
);
    logic                  score_done;
    logic [8*N-1:0]        score_bus;
    logic [DATA_W*N-1:0]   data_bus;
    logic [DATA_W-1:0]     out_data;
    logic [7:0]            out_rank;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output score_done, score_bus, data_bus, out_ready,
        input  out_data, out_rank, out_valid, out_last
    );

    modport slave (
        input  score_done, score_bus, data_bus, out_ready,
        output out_data, out_rank, out_valid, out_last
    );
endinterface

// File: rtl/rank_serializer.sv
// Captures a ranked frame into a rank-indexed buffer, validates the rank
// permutation and streams the TOP_K largest words out, largest first.
//
// state | meaning
// IDLE  | waiting for score_done; the only state that accepts a frame
// CHECK | one cycle: range flag and occupancy mask decide accept/reject
// EMIT  | presenting words from rank N downwards on the valid/ready port
module rank_serializer #(
    parameter int N      = 16,
    parameter int DATA_W = 20,
    parameter int TOP_K  = 16
) (
    input  logic               clk,
    input  logic               rst,
    rank_serializer_if.slave   bus,
    output logic               busy,
    output logic               frame_err,
    output logic [7:0]         overrun_cnt
);
    localparam int         IDX_W     = $clog2(N + 1);
    localparam logic [7:0] RANK_MAX  = 8'(N);
    localparam logic [7:0] RANK_LAST = 8'(N - TOP_K + 1);

    typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [N:1][DATA_W-1:0]  rbuf_q, rbuf_d;
    logic [N:1]              mask_q, mask_d;
    logic                    range_err_q, range_err_d;
    logic [7:0]              ptr_q, ptr_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic [7:0]              out_rank_q, out_rank_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              overrun_q, overrun_d;
    logic [7:0]              lane_rank;
    logic [7:0]              nxt_rank;

    always_comb begin
        state_d     = state_q;
        rbuf_d      = rbuf_q;
        mask_d      = mask_q;
        range_err_d = range_err_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_rank_d  = out_rank_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        lane_rank   = 8'd0;
        nxt_rank    = ptr_q - 8'd1;

        // Frames arriving outside IDLE are dropped, including the cycle EMIT ends.
        if (bus.score_done && state_q != IDLE && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (bus.score_done) begin
                    mask_d      = '0;
                    range_err_d = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        lane_rank = bus.score_bus[8*i +: 8];
                        if (lane_rank >= 8'd1 && lane_rank <= RANK_MAX) begin
                            rbuf_d[IDX_W'(lane_rank)] = bus.data_bus[DATA_W*i +: DATA_W];
                            mask_d[IDX_W'(lane_rank)] = 1'b1;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A duplicate rank always leaves some other rank unfilled.
                if (range_err_q || !(&mask_q)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    ptr_d       = RANK_MAX;
                    out_valid_d = 1'b1;
                    out_data_d  = rbuf_q[N];
                    out_rank_d  = RANK_MAX;
                    out_last_d  = (RANK_MAX == RANK_LAST);
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        ptr_d      = nxt_rank;
                        out_data_d = rbuf_q[IDX_W'(nxt_rank)];
                        out_rank_d = nxt_rank;
                        out_last_d = (nxt_rank == RANK_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rbuf_q      <= '0;
            mask_q      <= '0;
            range_err_q <= 1'b0;
            ptr_q       <= 8'd0;
            out_data_q  <= '0;
            out_rank_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            rbuf_q      <= rbuf_d;
            mask_q      <= mask_d;
            range_err_q <= range_err_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_rank_q  <= out_rank_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_rank  = out_rank_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;
    assign overrun_cnt   = overrun_q;
endmodule

// File: tb/tb_rank_serializer.sv
// Directed bench for rank_serializer: a TOP_K=16 instance and a TOP_K=4
// instance share stimulus; expected words are queued when a frame is sent.
module tb_rank_serializer;
    localparam int N = 16;
    localparam int DW = 20;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [7:0]    r;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              sd = 1'b0;
    logic              rdy = 1'b1;
    logic              sel = 1'b0;
    logic [8*N-1:0]    sbus = '0;
    logic [DW*N-1:0]   dbus = '0;

    rank_serializer_if #(.N(N), .DATA_W(DW)) if16 ();
    rank_serializer_if #(.N(N), .DATA_W(DW)) if4 ();

    assign if16.score_done = sd & ~sel;
    assign if16.score_bus  = sbus;
    assign if16.data_bus   = dbus;
    assign if16.out_ready  = rdy;
    assign if4.score_done  = sd & sel;
    assign if4.score_bus   = sbus;
    assign if4.data_bus    = dbus;
    assign if4.out_ready   = rdy;

    logic       busy16, fe16, busy4, fe4;
    logic [7:0] ov16, ov4;

    rank_serializer #(.N(N), .DATA_W(DW), .TOP_K(16)) dut16 (
        .clk(clk), .rst(rst), .bus(if16), .busy(busy16), .frame_err(fe16), .overrun_cnt(ov16)
    );
    rank_serializer #(.N(N), .DATA_W(DW), .TOP_K(4)) dut4 (
        .clk(clk), .rst(rst), .bus(if4), .busy(busy4), .frame_err(fe4), .overrun_cnt(ov4)
    );

    logic [DW-1:0] o_data;
    logic [7:0]    o_rank, o_ov;
    logic          o_valid, o_last, o_busy, o_fe;
    always_comb begin
        o_data  = sel ? if4.out_data  : if16.out_data;
        o_rank  = sel ? if4.out_rank  : if16.out_rank;
        o_valid = sel ? if4.out_valid : if16.out_valid;
        o_last  = sel ? if4.out_last  : if16.out_last;
        o_busy  = sel ? busy4 : busy16;
        o_fe    = sel ? fe4 : fe16;
        o_ov    = sel ? ov4 : ov16;
    end

    int checks = 0;
    int errors = 0;
    int cur_k  = 16;
    logic [7:0]    rk [N];
    logic [DW-1:0] dt [N];
    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            sbus[8*i +: 8]   = rk[i];
            dbus[DW*i +: DW] = dt[i];
        end
    endtask

    // Valid iff every rank 1..N is carried by exactly one lane; pushes the
    // TOP_K expected words of a valid frame onto the scoreboard.
    function automatic bit model_push();
        int cnt [N+1];
        int lane_of [N+1];
        bit ok = 1'b1;
        exp_t e;
        for (int r = 0; r <= N; r++) begin
            cnt[r] = 0;
            lane_of[r] = 0;
        end
        for (int i = 0; i < N; i++)
            if (rk[i] >= 1 && rk[i] <= N) begin
                cnt[rk[i]]++;
                lane_of[rk[i]] = i;
            end else ok = 1'b0;
        for (int r = 1; r <= N; r++)
            if (cnt[r] != 1) ok = 1'b0;
        if (ok)
            for (int r = N; r > N - cur_k; r--) begin
                e.d = dt[lane_of[r]];
                e.r = 8'(r);
                e.l = (r == N - cur_k + 1);
                sb.push_back(e);
            end
        return ok;
    endfunction

    task automatic drain(input int mode, input bit drop_on_last);
        int got = 0;
        int cyc = 0;
        while (got < cur_k && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (drop_on_last && got == cur_k - 1 && rdy) sd = 1'b1;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("extra_word", o_valid, 1'b0);
                end else begin
                    check("out_data", o_data, sb[0].d);
                    check("out_rank", o_rank, sb[0].r);
                    check("out_last", o_last, sb[0].l);
                    if (rdy) begin
                        void'(sb.pop_front());
                        got++;
                    end
                end
            end
            tick();
            sd = 1'b0;
            cyc++;
        end
        rdy = 1'b1;
        check("word_count", got, cur_k);
        check("valid_after", o_valid, 1'b0);
        check("busy_after", o_busy, 1'b0);
    endtask

    task automatic run_frame(input int mode, input bit drop_on_last);
        bit ok;
        ok = model_push();
        pack();
        sd = 1'b1;
        tick();
        sd = 1'b0;
        check("busy_check", o_busy, 1'b1);
        check("early_valid", o_valid, 1'b0);
        tick();
        if (ok) begin
            check("first_valid", o_valid, 1'b1);
            check("no_err", o_fe, 1'b0);
            drain(mode, drop_on_last);
        end else begin
            check("frame_err", o_fe, 1'b1);
            check("err_no_valid", o_valid, 1'b0);
            check("err_busy", o_busy, 1'b0);
            tick();
            check("frame_err_end", o_fe, 1'b0);
            check("err_no_valid2", o_valid, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ferr", o_fe, 1'b0);
        check("rst_ovr", o_ov, 8'd0);
        check("rst_data", o_data, 20'd0);
        check("rst_rank", o_rank, 8'd0);
        check("rst_last", o_last, 1'b0);
        rst = 1'b0;
        tick();

        // identity frame
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(100 + i); end
        run_frame(0, 1'b0);

        // backpressure with ready pattern 1,0,0
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(i * 3 + 7); end
        run_frame(1, 1'b0);

        // duplicate rank 5 on lanes 3 and 7, rank 12 missing
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(500 + i); end
        rk[3] = 8'd5; rk[4] = 8'd4; rk[7] = 8'd5; rk[11] = 8'd8;
        run_frame(0, 1'b0);
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(600 + i); end
        run_frame(0, 1'b0);

        // out-of-range ranks
        rk[0] = 8'd0;
        run_frame(0, 1'b0);
        rk[0] = 8'd1; rk[5] = 8'd17;
        run_frame(0, 1'b0);
        check("ovr_none", o_ov, 8'd0);

        // overrun during EMIT, then reset mid-frame
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(100 + i); end
        void'(model_push());
        pack();
        rdy = 1'b0;
        sd = 1'b1;
        tick();
        sd = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N; i++) dt[i] = DW'(9000 + j);
            pack();
            sd = 1'b1;
            tick();
            sd = 1'b0;
            tick();
        end
        check("ovr_three", o_ov, 8'd3);
        check("stall_hold", o_data, sb[0].d);
        rdy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check("ovr_word", o_data, sb[0].d);
            check("ovr_rank", o_rank, sb[0].r);
            void'(sb.pop_front());
            tick();
        end
        check("pre_rst_rank", o_rank, sb[0].r);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_ovr", o_ov, 8'd0);
        check("mid_rst_last", o_last, 1'b0);
        tick();
        check("post_rst_valid", o_valid, 1'b0);

        // reversed frame, with a frame strobe on the final handshake
        for (int i = 0; i < N; i++) begin rk[i] = 8'(16 - i); dt[i] = DW'(i); end
        run_frame(0, 1'b1);
        check("drop_on_finish", o_ovr_val(), 8'd1);
        tick();
        check("drop_stays_idle", o_busy, 1'b0);

        // TOP_K = 4 instance
        sel = 1'b1;
        cur_k = 4;
        tick();
        for (int i = 0; i < N; i++) begin rk[i] = 8'(i + 1); dt[i] = DW'(200 + i); end
        run_frame(0, 1'b0);
        check("k4_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [7:0] o_ovr_val();
        return o_ov;
    endfunction
endmodule
